// File: rtl/pc_fetch_reg_if.sv
// PC fetch stage bundle: control/redirect inputs, fetch handshake, debug status.
// Latency: wires only, no state.
// Backpressure: pc_ready from the fetch side holds an offered pc_out stable.
interface pc_fetch_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             ena;
  logic             redirect;
  logic [WIDTH-1:0] redirect_addr;
  logic             pc_ready;
  logic [WIDTH-1:0] pc_out;
  logic             pc_valid;
  logic             misalign_err;
  logic [CNT_W-1:0] inst_count;

  // PC register side: sources the fetch offer and status.
  modport master (
    input  ena,
    input  redirect,
    input  redirect_addr,
    input  pc_ready,
    output pc_out,
    output pc_valid,
    output misalign_err,
    output inst_count
  );

  // Control/fetch side: drives enable, redirects and ready.
  modport slave (
    output ena,
    output redirect,
    output redirect_addr,
    output pc_ready,
    input  pc_out,
    input  pc_valid,
    input  misalign_err,
    input  inst_count
  );
endinterface

// File: rtl/pc_fetch_reg.sv
// Program-counter register: offers pc_out to fetch, steps +4 per accept, takes redirects, traps misaligned targets.
// Latency: redirect or accept visible on pc_out one cycle after the sampling edge; all outputs registered.
// Backpressure: pc_out held stable while pc_valid & !pc_ready; offer withdrawn only when ena drops.
module pc_fetch_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               CNT_W     = 16
) (
  input logic            CLK,
  input logic            RST,
  pc_fetch_reg_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic             accept;
  logic             target_misaligned;
  logic [CNT_W-1:0] cnt_inc;

  assign accept            = bus.pc_valid & bus.pc_ready;
  assign target_misaligned = (bus.redirect_addr[1:0] != 2'b00);

  // Saturating increment of the accepted-fetch counter.
  always_comb begin
    cnt_inc = bus.inst_count;
    if (bus.inst_count != CNT_MAX) begin
      cnt_inc = bus.inst_count + 1'b1;
    end
  end

  // Fetch FSM with all outputs registered; wrap at 2^WIDTH on +4 is intentional.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      bus.pc_out       <= RESET_VEC;
      bus.pc_valid     <= 1'b0;
      bus.misalign_err <= 1'b0;
      bus.inst_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Entering RUN re-offers the held PC without advancing it.
          if (bus.ena) begin
            state        <= RUN;
            bus.pc_valid <= 1'b1;
          end
        end

        RUN: begin
          // The accepted address is always counted, even if a redirect replaces it.
          if (accept) begin
            bus.inst_count <= cnt_inc;
          end
          if (!bus.ena) begin
            if (accept) begin
              bus.pc_out <= bus.pc_out + PC_STEP;
            end
            state        <= IDLE;
            bus.pc_valid <= 1'b0;
          end else if (bus.redirect && !target_misaligned) begin
            bus.pc_out <= bus.redirect_addr;
          end else if (bus.redirect) begin
            // Keep the faulting target visible for debug.
            bus.pc_out       <= bus.redirect_addr;
            bus.pc_valid     <= 1'b0;
            bus.misalign_err <= 1'b1;
            state            <= HALT;
          end else if (accept) begin
            bus.pc_out <= bus.pc_out + PC_STEP;
          end
        end

        HALT: begin
          // Frozen until reset.
          bus.pc_valid <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          bus.pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Bench for pc_fetch_reg: default instance for run/backpressure/redirect/trap, small instance for wrap/saturate.
// Latency: expected outputs queued per driven cycle, popped one cycle later.
// Backpressure: exercised through pc_ready and ena drop sequences.
module tb_pc_fetch_reg;

  logic clk;
  logic rst_a;
  logic rst_b;

  pc_fetch_reg_if #(.WIDTH(32), .CNT_W(16)) bus_a ();
  pc_fetch_reg_if #(.WIDTH(32), .CNT_W(2))  bus_b ();

  pc_fetch_reg #(
    .WIDTH(32), .RESET_VEC(32'h0000_0000), .CNT_W(16)
  ) dut_a (
    .CLK(clk), .RST(rst_a), .bus(bus_a)
  );

  pc_fetch_reg #(
    .WIDTH(32), .RESET_VEC(32'hFFFF_FFF8), .CNT_W(2)
  ) dut_b (
    .CLK(clk), .RST(rst_b), .bus(bus_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] epc, input logic ev, input logic ee, input logic [15:0] ec);
    exp_t e;
    e.pc  = epc;
    e.vld = ev;
    e.err = ee;
    e.cnt = ec;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input bit sel, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s scoreboard empty got=%0d exp=1", tag, sb.size());
      return;
    end
    e = sb.pop_front();
    if (!sel) begin
      chk({tag, ".pc"},  bus_a.pc_out, e.pc);
      chk({tag, ".vld"}, {31'b0, bus_a.pc_valid}, {31'b0, e.vld});
      chk({tag, ".err"}, {31'b0, bus_a.misalign_err}, {31'b0, e.err});
      chk({tag, ".cnt"}, {16'b0, bus_a.inst_count}, {16'b0, e.cnt});
    end else begin
      chk({tag, ".pc"},  bus_b.pc_out, e.pc);
      chk({tag, ".vld"}, {31'b0, bus_b.pc_valid}, {31'b0, e.vld});
      chk({tag, ".err"}, {31'b0, bus_b.misalign_err}, {31'b0, e.err});
      chk({tag, ".cnt"}, {30'b0, bus_b.inst_count}, {16'b0, e.cnt});
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, compare #1 after the edge.
  task automatic step(input bit sel, input string tag,
                      input logic en, input logic rd, input logic [31:0] ra, input logic rdy,
                      input logic [31:0] epc, input logic ev, input logic ee, input logic [15:0] ec);
    if (!sel) begin
      bus_a.ena = en; bus_a.redirect = rd; bus_a.redirect_addr = ra; bus_a.pc_ready = rdy;
    end else begin
      bus_b.ena = en; bus_b.redirect = rd; bus_b.redirect_addr = ra; bus_b.pc_ready = rdy;
    end
    push_exp(epc, ev, ee, ec);
    @(posedge clk);
    #1;
    pop_cmp(sel, tag);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.ena = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_addr = '0; bus_a.pc_ready = 1'b0;
    bus_b.ena = 1'b0; bus_b.redirect = 1'b0; bus_b.redirect_addr = '0; bus_b.pc_ready = 1'b0;

    // Reset applied asynchronously, then held for two cycles.
    #1;
    push_exp(32'h0, 1'b0, 1'b0, 16'd0);
    pop_cmp(1'b0, "rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    push_exp(32'h0, 1'b0, 1'b0, 16'd0);
    pop_cmp(1'b0, "rst_hold");
    rst_a = 1'b0;

    // Reset then run: valid one cycle after ena, PC 0,4,8,C.
    step(0, "run0", 1, 0, 32'h0, 1, 32'h0,  1, 0, 16'd0);
    step(0, "run1", 1, 0, 32'h0, 1, 32'h4,  1, 0, 16'd1);
    step(0, "run2", 1, 0, 32'h0, 1, 32'h8,  1, 0, 16'd2);
    step(0, "run3", 1, 0, 32'h0, 1, 32'hC,  1, 0, 16'd3);
    step(0, "run4", 1, 0, 32'h0, 1, 32'h10, 1, 0, 16'd4);

    // Backpressure at 0x10.
    for (int i = 0; i < 3; i++) begin
      step(0, "bp_hold", 1, 0, 32'h0, 0, 32'h10, 1, 0, 16'd4);
    end
    step(0, "bp_rel", 1, 0, 32'h0, 1, 32'h14, 1, 0, 16'd5);

    // Advance to 0x20, then redirect with simultaneous accept.
    step(0, "adv18", 1, 0, 32'h0, 1, 32'h18, 1, 0, 16'd6);
    step(0, "adv1c", 1, 0, 32'h0, 1, 32'h1C, 1, 0, 16'd7);
    step(0, "adv20", 1, 0, 32'h0, 1, 32'h20, 1, 0, 16'd8);
    step(0, "redir", 1, 1, 32'h100, 1, 32'h100, 1, 0, 16'd9);
    step(0, "post_redir", 1, 0, 32'h0, 1, 32'h104, 1, 0, 16'd10);

    // Enable drop with an unaccepted offer, then re-offer the same PC.
    step(0, "stall",   1, 0, 32'h0, 0, 32'h104, 1, 0, 16'd10);
    step(0, "ena_drop", 0, 0, 32'h0, 0, 32'h104, 0, 0, 16'd10);
    step(0, "reoffer",  1, 0, 32'h0, 0, 32'h104, 1, 0, 16'd10);
    // Enable drop with accept still advances and counts.
    step(0, "drop_acc", 0, 0, 32'h0, 1, 32'h108, 0, 0, 16'd11);
    // Redirect ignored in IDLE and in RUN with ena=0.
    step(0, "idle_redir", 0, 1, 32'h200, 0, 32'h108, 0, 0, 16'd11);
    step(0, "reoffer2",   1, 0, 32'h0,   0, 32'h108, 1, 0, 16'd11);
    step(0, "off_redir",  0, 1, 32'h300, 0, 32'h108, 0, 0, 16'd11);
    step(0, "reoffer3",   1, 0, 32'h0,   0, 32'h108, 1, 0, 16'd11);

    // Misaligned redirect traps into HALT, recording the target.
    step(0, "misalign", 1, 1, 32'h102, 0, 32'h102, 0, 1, 16'd11);
    step(0, "halt1", 1, 1, 32'h400, 1, 32'h102, 0, 1, 16'd11);
    step(0, "halt2", 0, 0, 32'h0,   1, 32'h102, 0, 1, 16'd11);
    step(0, "halt3", 1, 0, 32'h0,   0, 32'h102, 0, 1, 16'd11);

    // Reset mid-cycle clears without a clock edge.
    #2;
    rst_a = 1'b1;
    #1;
    push_exp(32'h0, 1'b0, 1'b0, 16'd0);
    pop_cmp(1'b0, "rst_mid");

    // Wrap and saturate on the small instance.
    @(posedge clk);
    #1;
    push_exp(32'hFFFF_FFF8, 1'b0, 1'b0, 16'd0);
    pop_cmp(1'b1, "b_rst");
    rst_b = 1'b0;
    step(1, "b_run0", 1, 0, 32'h0, 1, 32'hFFFF_FFF8, 1, 0, 16'd0);
    step(1, "b_run1", 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 1, 0, 16'd1);
    step(1, "b_wrap", 1, 0, 32'h0, 1, 32'h0000_0000, 1, 0, 16'd2);
    step(1, "b_run3", 1, 0, 32'h0, 1, 32'h0000_0004, 1, 0, 16'd3);
    step(1, "b_sat",  1, 0, 32'h0, 1, 32'h0000_0008, 1, 0, 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
